led_seq_ctrl: RTL and testbench

LED pattern sequencer that schedules the board LED output. It steps through a small pattern table at a programmable rate, in one-shot or loop mode, and raises a completion interrupt. It sits between the AXI register file of the LED/button peripheral and the led pins. When idle, the software LED value passes through.

---
 rtl/led_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED pattern sequencer placed between the LED/button register file and the LED pins.
//
// The block steps through a small pattern table at a programmable rate.
// A sequence can run once (one-shot) or loop back to entry 0.
// A one-shot run that completes sets a sticky done flag, which can raise an interrupt.
// While the sequencer is idle, the software LED value is passed through to the pins.
//
// Optional build macro: LED_SEQ_BTN_TRIG_EN
//   When defined, a masked button pulse can start a sequence from idle.
//   When undefined, btn_pulse and btn_mask have no effect.
//
// Ports:
//   clk, resetN    clock; synchronous active-low reset
//   start_i        one-cycle start request
//   stop_i         one-cycle abort request (wins over any start)
//   pause_i        level; freezes the running sequence
//   loop_en        1 = wrap to entry 0 after the last step; 0 = one-shot
//   len_m1         index of the last step
//   period         clocks per step (0 behaves as 1)
//   pat_we         pattern table write strobe
//   pat_widx       pattern table write index
//   pat_wdata      pattern table write data
//   sw_led         LED value driven while idle
//   btn_pulse      button rising-edge pulses
//   btn_mask       buttons allowed to trigger a start
//   irq_en         interrupt enable
//   irq_clr        clears the done flag
//   led            registered LED drive
//   busy           high whenever the sequencer is not idle
//   step_idx       current pattern index
//   done_flag      sticky one-shot completion flag
//   irq            done_flag gated by irq_en
module led_seq_ctrl #(
    parameter int unsigned LED_WIDTH = 4,
    parameter int unsigned BTN_WIDTH = 4,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned PER_W     = 24
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 pause_i,
    input  logic                 loop_en,
    input  logic [IDX_W-1:0]     len_m1,
    input  logic [PER_W-1:0]     period,
    input  logic                 pat_we,
    input  logic [IDX_W-1:0]     pat_widx,
    input  logic [LED_WIDTH-1:0] pat_wdata,
    input  logic [LED_WIDTH-1:0] sw_led,
    input  logic [BTN_WIDTH-1:0] btn_pulse,
    input  logic [BTN_WIDTH-1:0] btn_mask,
    input  logic                 irq_en,
    input  logic                 irq_clr,
    output logic [LED_WIDTH-1:0] led,
    output logic                 busy,
    output logic [IDX_W-1:0]     step_idx,
    output logic                 done_flag,
    output logic                 irq
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE
    } state_t;

    state_t               state;
    logic [LED_WIDTH-1:0] pat [DEPTH];
    logic [PER_W-1:0]     cnt;
    logic [PER_W-1:0]     reload;
    logic                 start_req;
    logic [IDX_W-1:0]     next_idx;

    // A period of 0 uses the same reload value as a period of 1.
    always_comb begin
        reload = '0;
        if (period != '0)
            reload = period - PER_W'(1);
    end

    always_comb next_idx = step_idx + IDX_W'(1);

`ifdef LED_SEQ_BTN_TRIG_EN
    always_comb start_req = start_i | (|(btn_pulse & btn_mask));
`else
    always_comb start_req = start_i;
    logic unused_btn;
    always_comb unused_btn = ^{btn_pulse, btn_mask};
`endif

    always_comb busy = (state != S_IDLE);
    always_comb irq  = done_flag & irq_en;

    // Pattern table: can be written at any time.
    // A new value is picked up the next time its index is loaded.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                pat[i] <= '0;
        end else if (pat_we) begin
            pat[pat_widx] <= pat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= S_IDLE;
            led       <= '0;
            step_idx  <= '0;
            cnt       <= '0;
            done_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    led      <= sw_led;
                    step_idx <= '0;
                    if (start_req && !stop_i)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    if (stop_i) begin
                        state    <= S_IDLE;
                        led      <= sw_led;
                        step_idx <= '0;
                    end else begin
                        step_idx <= '0;
                        led      <= pat[0];
                        cnt      <= reload;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop_i) begin
                        state    <= S_IDLE;
                        led      <= sw_led;
                        step_idx <= '0;
                    end else if (pause_i) begin
                        state <= S_PAUSE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - PER_W'(1);
                    end else if (step_idx != len_m1) begin
                        step_idx <= next_idx;
                        led      <= pat[next_idx];
                        cnt      <= reload;
                    end else if (loop_en) begin
                        step_idx <= '0;
                        led      <= pat[0];
                        cnt      <= reload;
                    end else begin
                        state     <= S_IDLE;
                        done_flag <= 1'b1;
                        step_idx  <= '0;
                        led       <= sw_led;
                    end
                end
                S_PAUSE: begin
                    if (stop_i) begin
                        state    <= S_IDLE;
                        led      <= sw_led;
                        step_idx <= '0;
                    end else if (!pause_i) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Placed last so that a clear wins over a set in the same cycle.
            if (irq_clr)
                done_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: self-checking bench for led_seq_ctrl.
//
// A behavioural model tracks the sequence in plain terms:
//   - a mode (idle, loading, active);
//   - a pause flag;
//   - the current step number;
//   - the number of cycles elapsed in the current step, compared against the step length.
// On every negative edge after reset, the model is compared against the DUT outputs.
// Some directed points are also checked against literal values.
module tb_led_seq_ctrl;

    localparam int unsigned LW = 4;
    localparam int unsigned BW = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned PW = 24;

    logic          clk = 1'b0;
    logic          resetN;
    logic          start_i, stop_i, pause_i, loop_en;
    logic [IW-1:0] len_m1;
    logic [PW-1:0] period;
    logic          pat_we;
    logic [IW-1:0] pat_widx;
    logic [LW-1:0] pat_wdata, sw_led;
    logic [BW-1:0] btn_pulse, btn_mask;
    logic          irq_en, irq_clr;
    logic [LW-1:0] led;
    logic          busy;
    logic [IW-1:0] step_idx;
    logic          done_flag, irq;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    led_seq_ctrl #(.LED_WIDTH(LW), .BTN_WIDTH(BW), .IDX_W(IW), .PER_W(PW)) dut (
        .clk(clk), .resetN(resetN), .start_i(start_i), .stop_i(stop_i),
        .pause_i(pause_i), .loop_en(loop_en), .len_m1(len_m1), .period(period),
        .pat_we(pat_we), .pat_widx(pat_widx), .pat_wdata(pat_wdata), .sw_led(sw_led),
        .btn_pulse(btn_pulse), .btn_mask(btn_mask), .irq_en(irq_en), .irq_clr(irq_clr),
        .led(led), .busy(busy), .step_idx(step_idx), .done_flag(done_flag), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int      m_mode;      // 0 idle, 1 loading, 2 active
    bit      m_paused;
    int      m_idx;
    int      m_age;
    int      m_len;       // cycles per step, latched at each step start
    int      m_led;
    bit      m_done;
    int      m_pat [8];

    always @(posedge clk) begin : model
        int  mode, idx, age, len, ledv;
        bit  paused, done, trig;
        mode = m_mode; idx = m_idx; age = m_age; len = m_len; ledv = m_led;
        paused = m_paused; done = m_done;
`ifdef LED_SEQ_BTN_TRIG_EN
        trig = start_i || ((btn_pulse & btn_mask) != 0);
`else
        trig = start_i;
`endif
        if (!resetN) begin
            mode = 0; idx = 0; age = 0; len = 1; ledv = 0; paused = 0; done = 0;
            for (int i = 0; i < 8; i++) m_pat[i] <= 0;
        end else begin
            if (mode != 0 && stop_i) begin
                mode = 0; ledv = sw_led; idx = 0;
            end else if (mode == 0) begin
                ledv = sw_led; idx = 0;
                if (trig && !stop_i) mode = 1;
            end else if (mode == 1) begin
                mode = 2; paused = 0; idx = 0; age = 0;
                ledv = m_pat[0];
                len = (period == 0) ? 1 : int'(period);
            end else if (paused) begin
                if (!pause_i) paused = 0;
            end else if (pause_i) begin
                paused = 1;
            end else begin
                age++;
                if (age == len) begin
                    age = 0;
                    len = (period == 0) ? 1 : int'(period);
                    if (idx != int'(len_m1)) begin
                        idx = (idx + 1) % 8; ledv = m_pat[idx];
                    end else if (loop_en) begin
                        idx = 0; ledv = m_pat[0];
                    end else begin
                        mode = 0; done = 1; idx = 0; ledv = sw_led;
                    end
                end
            end
            if (irq_clr) done = 0;
            if (pat_we) m_pat[pat_widx] <= int'(pat_wdata);
        end
        m_mode <= mode; m_idx <= idx; m_age <= age; m_len <= len; m_led <= ledv;
        m_paused <= paused; m_done <= done;
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("model_led",  int'(led),       m_led);
            cmp("model_busy", int'(busy),      int'(m_mode != 0));
            cmp("model_idx",  int'(step_idx),  m_idx);
            cmp("model_done", int'(done_flag), int'(m_done));
            cmp("model_irq",  int'(irq),       int'(m_done && irq_en));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1; tick(1); start_i = 1'b0;
    endtask

    task automatic write_pat(input int idx, input int val);
        pat_we = 1'b1; pat_widx = IW'(idx); pat_wdata = LW'(val);
        tick(1);
        pat_we = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; start_i = 0; stop_i = 0; pause_i = 0; loop_en = 0;
        len_m1 = '0; period = '0; pat_we = 0; pat_widx = '0; pat_wdata = '0;
        sw_led = 4'hA; btn_pulse = '0; btn_mask = '0; irq_en = 1'b1; irq_clr = 0;
        tick(1);
        cmp_en = 1'b1;
        tick(2);
        // 1: reset values, then pass-through
        cmp("rst_led", int'(led), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_irq", int'(irq), 0);
        resetN = 1'b1;
        tick(1);
        cmp("idle_passthru", int'(led), 'hA);

        write_pat(0, 1); write_pat(1, 2); write_pat(2, 4);

        // 2: one-shot, period 3
        len_m1 = 3'd2; period = 24'd3; loop_en = 0;
        pulse_start();                 // LOAD edge passed
        tick(1);  cmp("os_first", int'(led), 1);
        tick(2);  cmp("os_first_hold", int'(led), 1);
        tick(1);  cmp("os_second", int'(led), 2);
        tick(3);  cmp("os_third", int'(led), 4);
        tick(2);  cmp("os_third_hold", int'(led), 4);
        tick(1);
        cmp("os_end_busy", int'(busy), 0);
        cmp("os_end_led", int'(led), 'hA);
        cmp("os_end_done", int'(done_flag), 1);
        cmp("os_end_irq", int'(irq), 1);
        irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
        cmp("irq_clr", int'(irq), 0);

        // 3: loop, period 0 behaves as 1
        loop_en = 1'b1; period = '0;
        pulse_start();
        tick(1); cmp("loop_a", int'(led), 1);
        tick(1); cmp("loop_b", int'(led), 2);
        tick(1); cmp("loop_c", int'(led), 4);
        tick(1); cmp("loop_wrap", int'(led), 1);
        tick(5); cmp("loop_no_done", int'(done_flag), 0);
        sw_led = 4'h5; stop_i = 1'b1; tick(1); stop_i = 1'b0;
        cmp("stop_busy", int'(busy), 0);
        cmp("stop_led", int'(led), 5);

        // 4: pause mid-step, then a start while busy
        loop_en = 0; period = 24'd4;
        pulse_start();
        tick(3);                       // LOAD result plus two counted cycles
        pause_i = 1'b1; tick(5); pause_i = 1'b0;
        cmp("pause_frozen", int'(led), 1);
        tick(2); cmp("pause_resume_hold", int'(led), 1);
        tick(1); cmp("pause_step_done", int'(led), 2);
        pulse_start();
        tick(1);
        cmp("busy_start_ignored_led", int'(led), 2);
        cmp("busy_start_ignored_idx", int'(step_idx), 1);
        stop_i = 1'b1; tick(1); stop_i = 1'b0;

        // 5: start and stop together in idle; clear in the same cycle as the set
        start_i = 1'b1; stop_i = 1'b1; tick(1); start_i = 0; stop_i = 0;
        tick(1); cmp("start_stop_idle", int'(busy), 0);
        period = 24'd1; len_m1 = '0;
        pulse_start();
        tick(1);                       // pat[0] shown; next edge is expiry
        irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
        cmp("clr_wins_busy", int'(busy), 0);
        cmp("clr_wins_done", int'(done_flag), 0);

        // 6: button trigger
        btn_mask = 4'b0100;
        btn_pulse = 4'b0001; tick(1); btn_pulse = '0;
        tick(1); cmp("btn_masked", int'(busy), 0);
        btn_pulse = 4'b0100; tick(1); btn_pulse = '0;
        tick(1);
`ifdef LED_SEQ_BTN_TRIG_EN
        cmp("btn_start", int'(busy), 1);
`else
        cmp("btn_start", int'(busy), 0);
`endif
        stop_i = 1'b1; tick(1); stop_i = 1'b0;

        // Longer looped run: table rewrites and a period change mid-run (model-checked)
        for (int i = 3; i < 8; i++) write_pat(i, i + 6);
        len_m1 = 3'd7; loop_en = 1'b1; period = 24'd2;
        pulse_start();
        tick(7);
        write_pat(5, 4'hF);
        period = 24'd1;
        tick(12);
        len_m1 = 3'd3;
        tick(10);
        stop_i = 1'b1; tick(1); stop_i = 1'b0;

        // Reset mid-sequence
        pulse_start(); tick(3);
        resetN = 1'b0; tick(1);
        cmp("midrst_led", int'(led), 0);
        cmp("midrst_busy", int'(busy), 0);
        resetN = 1'b1; tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
